add_sub_multicycle: RTL and testbench
=====================================

// Module: add_sub_multicycle
//
// PURPOSE
// - Sequential adder/subtractor. Computes in0+in1 or in0-in1 over several cycles, processing CHUNK bits per cycle, LSB chunk first.
// - Trades latency for a short carry chain per cycle. Used beside the combinational add_sub for timing and area comparisons.
// - Uses a go/done handshake, so it can be dropped into the same registered-I/O timing harness.
//
// PARAMETERS
// - WIDTH  32  operand/result width in bits.
// - CHUNK  8   bits processed per cycle. WIDTH % CHUNK must be 0; elaboration error otherwise.
//
// PORTS
// - clk   in   1      clock; all state changes on posedge.
// - rst   in   1      asynchronous, active-low reset.
// - go    in   1      start request; sampled only in IDLE or DONE.
// - in0   in   WIDTH  operand A; captured on the accepted go.
// - in1   in   WIDTH  operand B; captured on the accepted go.
// - sel   in   1      0 = A+B, 1 = A-B; captured on the accepted go.
// - out   out  WIDTH  result; updated only on completion, stable otherwise.
// - done  out  1      result valid; held until the next accepted go.
//
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, out=0, done=0, chunk count=0, operand/carry regs=0.
//   - Takes effect immediately, including mid-operation; a partial result is discarded.
// - N = WIDTH/CHUNK.
// - States and transitions:
//   - IDLE: on go=1, go to BUSY.
//   - BUSY: after the Nth chunk, go to DONE. go is ignored in BUSY: no restart, no queueing.
//   - DONE: on go=1, go to BUSY.
// - Accepted go (IDLE or DONE, go=1 at edge k):
//   - a_r <= in0; b_r <= sel ? ~in1 : in1; carry <= sel; count <= 0; done <= 0.
// - BUSY, each edge:
//   - {carry, sum} = a_r[CHUNK-1:0] + b_r[CHUNK-1:0] + carry.
//   - sum shifts into the result register from the MSB side; a_r and b_r shift right by CHUNK; count++.
// - Completion: at edge k+N, out <= assembled result, done <= 1, state <= DONE.
//   - Latency from accepted go to done=1 is exactly N cycles; CHUNK=WIDTH gives 1 cycle.
// - Arithmetic: modulo 2^WIDTH, two's complement. Final carry-out is discarded; no overflow flag.
// - done=1 with go=1 in the same cycle: new operation accepted and done drops next cycle.
//   - Back-to-back throughput is one result per N+1 cycles.
// - in0/in1/sel may change freely while BUSY without affecting the result.
// - out keeps the previous result while BUSY.
//
// STRUCTURE
// - Shared package add_sub_pkg holds:
//   - typedef enum logic [1:0] {IDLE, BUSY, DONE} add_sub_state_t;
//   - function int num_chunks(int width, int chunk) returning width/chunk.
// - One sub-module, add_sub_chunk #(CHUNK): combinational; ports a, b, cin, sum, cout.
//   - Instantiated once; it is the per-cycle datapath.
// - Top level: FSM, count (width $clog2(N+1)), operand shift registers, result register.
//
// TESTING  (WIDTH=32, CHUNK=8 unless noted)
// 1. Reset: rst=0 async mid-cycle -> out=0, done=0 immediately. After release, no done without go.
// 2. go, 0x000000FF + 0x00000001, sel=0 -> done=1 exactly 4 cycles later, out=0x00000100 (carry crosses chunks).
// 3. Subtract, 5 - 7, sel=1 -> out=0xFFFFFFFE. Also 0x80000000 - 1 -> 0x7FFFFFFF.
// 4. Wrap-around: 0xFFFFFFFF + 1 -> out=0x00000000, done=1.
// 5. Handshake:
//    - go pulses and in0/in1 changes while BUSY -> ignored; result matches the captured operands.
//    - go held high -> results every 5 cycles; done low for 4 cycles between results.
// 6. Reset during BUSY (cycle 2) -> out=0, done=0, IDLE; next op is correct.
//    - Repeat tests 2-4 with CHUNK=32 (1-cycle latency) and CHUNK=1 (32 cycles).
//    - Random regression against a reference model: (in0 ± in1) mod 2^WIDTH.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } add_sub_state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// One CHUNK-bit slice of the ripple datapath: {cout, sum} = a + b + cin.
module add_sub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] w_total;

  assign w_total = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);
  assign sum     = w_total[CHUNK-1:0];
  assign cout    = w_total[CHUNK];

endmodule

// File: rtl/add_sub_multicycle.sv
// Sequential adder/subtractor: CHUNK bits per cycle, LSB chunk first,
// go/done handshake with registered result.
module add_sub_multicycle
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             done
);

  localparam int unsigned N  = $unsigned(num_chunks(int'(WIDTH), int'(CHUNK)));
  localparam int unsigned CW = $clog2(N + 1);

  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_chunk_check
    $error("add_sub_multicycle: WIDTH must be a nonzero multiple of CHUNK");
  end

  add_sub_state_t r_state;
  add_sub_state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_next;

  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Each new chunk sum enters at the MSB end; after N steps the word is in order.
  assign w_acc_next = (r_acc >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (go)     w_state_nxt = BUSY;
      BUSY:    if (w_last) w_state_nxt = DONE;
      DONE:    if (go)     w_state_nxt = BUSY;
      default:             w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE, DONE: w_accept = go;
      BUSY: begin
        w_step = 1'b1;
        w_last = (r_count == CW'(N - 1));
      end
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on capture and seed the carry with sel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      out     <= '0;
      done    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in0;
      r_b     <= sel ? ~in1 : in1;
      r_carry <= sel;
      r_count <= '0;
      done    <= 1'b0;
    end else if (w_step) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_cout;
      r_count <= r_count + CW'(1);
      r_acc   <= w_acc_next;
      if (w_last) begin
        out  <= w_acc_next;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_multicycle.sv
// Directed and random checks of add_sub_multicycle at CHUNK = 8, 32 and 1.
module tb_add_sub_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  gov = 3'b000;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        sel = 1'b0;
  logic [31:0] outs [3];
  logic [2:0]  dones;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_sub_multicycle #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .go(gov[0]), .in0(in0), .in1(in1), .sel(sel),
    .out(outs[0]), .done(dones[0])
  );
  add_sub_multicycle #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .go(gov[1]), .in0(in0), .in1(in1), .sel(sel),
    .out(outs[1]), .done(dones[1])
  );
  add_sub_multicycle #(.WIDTH(32), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .go(gov[2]), .in0(in0), .in1(in1), .sel(sel),
    .out(outs[2]), .done(dones[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int lat_of(input int which);
    return (which == 0) ? 4 : (which == 1) ? 1 : 32;
  endfunction

  // One go pulse, then done must be low one cycle before the latency and high at it.
  task automatic run(input int which, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] exp, input string tag);
    int lat;
    lat = lat_of(which);
    in0 = a; in1 = b; sel = s;
    gov[which] = 1'b1;
    cyc(1);
    gov[which] = 1'b0;
    if (lat > 1) cyc(lat - 1);
    check({tag, "_early"}, 32'(dones[which]), 32'd0);
    cyc(1);
    check({tag, "_done"}, 32'(dones[which]), 32'd1);
    check({tag, "_out"},  outs[which], exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    string       nm;

    // Reset state while rst is held low
    #1;
    check("rst_out",  outs[0], 32'd0);
    check("rst_done", 32'(dones), 32'd0);
    #20 rst = 1'b1;
    cyc(6);
    check("idle_no_done", 32'(dones), 32'd0);

    for (int w = 0; w < 3; w++) begin
      nm = $sformatf("c%0d", (w == 0) ? 8 : (w == 1) ? 32 : 1);
      run(w, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, {nm, "_carry"});
      run(w, 32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, {nm, "_sub_neg"});
      run(w, 32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, {nm, "_sub_min"});
      run(w, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, {nm, "_wrap"});
    end

    // go pulses and operand changes while BUSY are ignored; out holds old result
    run(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, "pre_ign");
    in0 = 32'h0000_1000; in1 = 32'h0000_0001; sel = 1'b1;
    gov[0] = 1'b1;
    cyc(1);
    gov[0] = 1'b0;
    in0 = 32'hDEAD_BEEF; in1 = 32'hCAFE_F00D; sel = 1'b0;
    cyc(1);
    gov[0] = 1'b1;
    check("busy_hold_out", outs[0], 32'h2345_6789);
    cyc(1);
    gov[0] = 1'b0;
    check("busy_hold_done", 32'(dones[0]), 32'd0);
    cyc(2);
    check("ign_done", 32'(dones[0]), 32'd1);
    check("ign_out",  outs[0], 32'h0000_0FFF);

    // go held high: one result every 5 cycles
    in0 = 32'd100; in1 = 32'd23; sel = 1'b0;
    gov[0] = 1'b1;
    cyc(1);
    cyc(4);
    check("hold_done1", 32'(dones[0]), 32'd1);
    check("hold_out1",  outs[0], 32'd123);
    in0 = 32'd100; in1 = 32'd23; sel = 1'b1;
    cyc(1);
    check("hold_drop", 32'(dones[0]), 32'd0);
    cyc(3);
    check("hold_low4", 32'(dones[0]), 32'd0);
    check("hold_keep", outs[0], 32'd123);
    cyc(1);
    gov[0] = 1'b0;
    check("hold_done2", 32'(dones[0]), 32'd1);
    check("hold_out2",  outs[0], 32'd77);

    // Asynchronous reset mid-cycle during BUSY discards the partial result
    in0 = 32'h0F0F_0F0F; in1 = 32'h0101_0101; sel = 1'b0;
    gov[0] = 1'b1;
    cyc(1);
    gov[0] = 1'b0;
    cyc(2);
    #2 rst = 1'b0;
    #1;
    check("async_out",  outs[0], 32'd0);
    check("async_done", 32'(dones), 32'd0);
    #2 rst = 1'b1;
    cyc(6);
    check("post_rst_idle", 32'(dones[0]), 32'd0);
    run(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, "post_rst");

    // Random operands against (a +/- b) mod 2^32
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 6; i++) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        run(w, ra, rb, rs, rs ? (ra - rb) : (ra + rb), $sformatf("rnd%0d_%0d", w, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
